// File: rtl/x_player_pkg.sv
// Shared types and constants for the x_player sample playback engine.
package x_player_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} player_state_e;

  localparam int DIV_MIN = 1;

  function automatic int park_code(input int bin_w);
    return 1 << (bin_w - 1);
  endfunction

endpackage

// File: rtl/x_player_timer.sv
// Sample period down-counter: reloads on each sample update, flags the last cycle of a period.
module x_player_timer #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_reload,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Reload value div_eff plus the terminal zero cycle gives a period of div_eff+1.
  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/x_player.sv
// Sample playback engine: fetches a block from x_mem and holds each code for one sample period.
module x_player
  import x_player_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BIN_W  = 6,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_loop,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [BIN_W-1:0]  o_bin,
  output logic              o_bin_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [BIN_W-1:0] PARK = BIN_W'(park_code(BIN_W));

  function automatic logic [BIN_W-1:0] to_bin(input logic [DATA_W-1:0] d);
    return d[DATA_W-1 -: BIN_W];
  endfunction

  player_state_e     r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [DIV_W-1:0]  r_div_eff;
  logic              r_loop;
  logic [ADDR_W-1:0] r_idx;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_pend;
  logic [DATA_W-1:0] r_buf;
  logic [BIN_W-1:0]  r_bin;
  logic              r_bin_valid;
  logic              r_done;

  logic              w_expire;
  logic              w_load;
  logic [DATA_W-1:0] w_new_data;
  logic [ADDR_W-1:0] w_new_idx;
  logic              w_new_is_end;
  logic              w_last;
  logic [ADDR_W-1:0] w_next_addr;

  // Data arriving in the same cycle as the period end bypasses the prefetch buffer.
  assign w_load       = !i_stop && (((r_state == PRIME) && r_pend) ||
                                    ((r_state == RUN) && w_expire));
  assign w_new_data   = r_pend ? i_rd_data : r_buf;
  assign w_new_idx    = ((r_state == PRIME) || (r_idx == r_len)) ? '0 : r_idx + 1'b1;
  assign w_new_is_end = (w_new_idx == r_len);
  assign w_last       = w_new_is_end && !r_loop;
  // r_rd_addr always holds the address of the sample being loaded now.
  assign w_next_addr  = w_new_is_end ? r_base : r_rd_addr + 1'b1;

  x_player_timer #(.DIV_W(DIV_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_reload   (w_load),
    .i_load_val (r_div_eff),
    .o_expire   (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_div_eff   <= '0;
      r_loop      <= 1'b0;
      r_idx       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_pend      <= 1'b0;
      r_bin       <= PARK;
      r_bin_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_en     <= 1'b0;
      r_bin_valid <= 1'b0;
      r_done      <= 1'b0;
      r_pend      <= r_rd_en;
      if (r_pend) r_buf <= i_rd_data;

      if ((r_state != IDLE) && i_stop) begin
        r_state <= IDLE;
        r_bin   <= PARK;
        r_pend  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start && !i_stop) begin
              r_base    <= i_base;
              r_len     <= i_len;
              r_loop    <= i_loop;
              r_div_eff <= (i_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : i_div;
              r_rd_en   <= 1'b1;
              r_rd_addr <= i_base;
              r_state   <= PRIME;
            end
          end
          PRIME, RUN: begin
            if (w_load) begin
              r_bin       <= to_bin(w_new_data);
              r_bin_valid <= 1'b1;
              r_idx       <= w_new_idx;
              if (w_last) begin
                r_state <= DRAIN;
              end else begin
                r_state   <= RUN;
                r_rd_en   <= 1'b1;
                r_rd_addr <= w_next_addr;
              end
            end
          end
          DRAIN: begin
            if (w_expire) begin
              r_bin   <= PARK;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_bin       = r_bin;
  assign o_bin_valid = r_bin_valid;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_x_player.sv
// Scoreboard bench for x_player with a 1-cycle-latency x_mem model.
module tb_x_player;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int BIN_W  = 6;
  localparam int DIV_W  = 16;
  localparam int PARK   = 32;

  logic              clk;
  logic              i_rst;
  logic              i_start;
  logic              i_stop;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W-1:0] i_len;
  logic [DIV_W-1:0]  i_div;
  logic              i_loop;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [BIN_W-1:0]  o_bin;
  logic              o_bin_valid;
  logic              o_busy;
  logic              o_done;

  x_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BIN_W(BIN_W), .DIV_W(DIV_W)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_base      (i_base),
    .i_len       (i_len),
    .i_div       (i_div),
    .i_loop      (i_loop),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (rd_data),
    .o_bin       (o_bin),
    .o_bin_valid (o_bin_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];
  always @(posedge clk) if (o_rd_en) rd_data <= mem[o_rd_addr];

  typedef struct {int val; int cyc;} exp_t;
  exp_t bin_q[$];
  exp_t rd_q[$];
  int   done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_bin(input int v, input int c);
    exp_t e;
    e.val = v; e.cyc = c;
    bin_q.push_back(e);
  endtask

  task automatic push_rd(input int a, input int c);
    exp_t e;
    e.val = a; e.cyc = c;
    rd_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    exp_t e;
    int   dc;
    if (o_bin_valid) begin
      check("bin_valid_expected", int'(bin_q.size() > 0), 1);
      if (bin_q.size() > 0) begin
        e = bin_q.pop_front();
        check("bin_value", int'(o_bin), e.val);
        check("bin_cycle", cyc, e.cyc);
      end
    end
    if (o_rd_en) begin
      check("rd_expected", int'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        check("rd_addr", int'(o_rd_addr), e.val);
        check("rd_cycle", cyc, e.cyc);
      end
    end
    if (o_done) begin
      check("done_expected", int'(done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        dc = done_q.pop_front();
        check("done_cycle", cyc, dc);
        check("done_bin_park", int'(o_bin), PARK);
        check("done_busy", int'(o_busy), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] l,
                          input logic [15:0] d, input logic lp, output int s);
    i_base  = b;
    i_len   = l;
    i_div   = d;
    i_loop  = lp;
    i_start = 1'b1;
    s = cyc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_bin"},   int'(o_bin),       PARK);
    check({tag, "_busy"},  int'(o_busy),      0);
    check({tag, "_rd_en"}, int'(o_rd_en),     0);
    check({tag, "_valid"}, int'(o_bin_valid), 0);
    check({tag, "_done"},  int'(o_done),      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h40; mem[8'h11] = 8'h80; mem[8'h12] = 8'hC0;
    mem[8'h20] = 8'h04; mem[8'h21] = 8'hFC;
    mem[8'h40] = 8'h00; mem[8'h41] = 8'hFF; mem[8'h42] = 8'h84; mem[8'h43] = 8'h7C;
    mem[8'hFE] = 8'h10; mem[8'hFF] = 8'h20; mem[8'h00] = 8'h30; mem[8'h01] = 8'hF0;
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_base = '0; i_len = '0; i_div = '0; i_loop = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    tick();
    check_parked("reset");

    // Single pass, P=4, with an ignored start mid-run.
    do_start(8'h10, 8'd2, 16'd3, 1'b0, s);
    push_rd(8'h10, s + 1); push_rd(8'h11, s + 3); push_rd(8'h12, s + 7);
    push_bin(16, s + 3); push_bin(32, s + 7); push_bin(48, s + 11);
    done_q.push_back(s + 15);
    wait_until(s + 5);
    i_base = 8'h30; i_len = 8'd0; i_div = 16'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_during_run", int'(o_busy), 1);
    wait_until(s + 18);
    check("idle_after_done", int'(o_busy), 0);

    // Loop of two samples, P=3, then stop.
    do_start(8'h20, 8'd1, 16'd2, 1'b1, s);
    push_rd(8'h20, s + 1);
    for (int k = 0; k < 5; k++) begin
      push_bin((k % 2 == 0) ? 1 : 63, s + 3 + 3 * k);
      push_rd((k % 2 == 0) ? 8'h21 : 8'h20, s + 3 + 3 * k);
    end
    wait_until(s + 16);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check_parked("stop");
    tick(); tick(); tick(); tick();
    check("stop_stays_idle", int'(o_busy), 0);

    // div=0 behaves as div=1: P=2, exercises the buffer bypass.
    do_start(8'h40, 8'd3, 16'd0, 1'b0, s);
    push_rd(8'h40, s + 1); push_rd(8'h41, s + 3); push_rd(8'h42, s + 5); push_rd(8'h43, s + 7);
    push_bin(0, s + 3); push_bin(63, s + 5); push_bin(33, s + 7); push_bin(31, s + 9);
    done_q.push_back(s + 11);
    wait_until(s + 14);

    // Address wrap FE, FF, 00, 01.
    do_start(8'hFE, 8'd3, 16'd1, 1'b0, s);
    push_rd(8'hFE, s + 1); push_rd(8'hFF, s + 3); push_rd(8'h00, s + 5); push_rd(8'h01, s + 7);
    push_bin(4, s + 3); push_bin(8, s + 5); push_bin(12, s + 7); push_bin(60, s + 9);
    done_q.push_back(s + 11);
    wait_until(s + 14);

    // Reset mid-run.
    do_start(8'h10, 8'd2, 16'd3, 1'b1, s);
    push_rd(8'h10, s + 1); push_rd(8'h11, s + 3); push_rd(8'h12, s + 7);
    push_bin(16, s + 3); push_bin(32, s + 7);
    wait_until(s + 8);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_parked("rst_mid_run");
    tick();
    check("rst_no_read_after", int'(o_rd_en), 0);
    tick(); tick(); tick(); tick();

    // Start and stop together while idle.
    i_start = 1'b1; i_stop = 1'b1; i_base = 8'h10; i_len = 8'd2; i_div = 16'd3; i_loop = 1'b0;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
    check("start_stop_busy", int'(o_busy), 0);
    tick();
    check("start_stop_busy_later", int'(o_busy), 0);
    check("start_stop_rd_en", int'(o_rd_en), 0);
    tick(); tick(); tick(); tick();

    check("bin_q_drained", int'(bin_q.size()), 0);
    check("rd_q_drained", int'(rd_q.size()), 0);
    check("done_q_drained", int'(done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
